// File: rtl/lfsr_checker_pkg.sv
// rtl/lfsr_checker_pkg.sv - shared 12-bit generator constants, state encoding and step function
package lfsr_checker_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int          LFSR_WIDTH = 12;
    localparam logic [11:0] LFSR_SEED  = 12'hB48;

    // Feedback taps at bit positions 0, 3, 5 and 11.
    localparam int          LFSR_TAP0  = 0;
    localparam int          LFSR_TAP1  = 3;
    localparam int          LFSR_TAP2  = 5;
    localparam int          LFSR_TAP3  = 11;
    localparam logic [11:0] LFSR_TAPS  = (12'd1 << LFSR_TAP0) | (12'd1 << LFSR_TAP1) |
                                         (12'd1 << LFSR_TAP2) | (12'd1 << LFSR_TAP3);

    localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

    function automatic logic [11:0] lfsr_next(input logic [11:0] w);
        return {w[10:0], ^(w & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - lock-and-flywheel checker for the 12-bit generator stream
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_TARGET = 4'(MISS_LIMIT);

    state_t      state_q, state_d;
    logic [11:0] pred_q, pred_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  miss_q, miss_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;
    logic        locked_q, locked_d;
    logic        match;
    logic        err_inc;

    assign match = (in_data == pred_q);

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        good_d  = good_q;
        miss_d  = miss_q;
        err_inc = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                ST_SEARCH: begin
                    // All-zero is the generator's lock-up value and can never seed a valid stream.
                    if (in_data != 12'd0) begin
                        pred_d  = lfsr_next(in_data);
                        good_d  = 4'd0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (match) begin
                        pred_d = lfsr_next(pred_q);
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else begin
                        pred_d = lfsr_next(in_data);
                        good_d = 4'd0;
                        if (in_data == 12'd0) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the prediction keeps running from its own history, never from input.
                    pred_d = lfsr_next(pred_q);
                    if (match) begin
                        miss_d = 4'd0;
                    end else begin
                        err_inc = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        if (miss_q + 4'd1 == MISS_TARGET) begin
                            state_d = ST_SEARCH;
                            miss_d  = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    good_d  = 4'd0;
                    miss_d  = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = 16'd0;
        end else if (err_inc && cnt_q != ERR_COUNT_MAX) begin
            cnt_d = cnt_q + 16'd1;
        end
        pulse_d  = err_inc;
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SEARCH;
            pred_q   <= 12'd0;
            good_q   <= 4'd0;
            miss_q   <= 4'd0;
            cnt_q    <= 16'd0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            locked_q <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - randomized bench for lfsr_checker against a behavioural model
module tb_lfsr_checker;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        in_valid, clr_cnt, in_valid2, clr_cnt2;
    logic [11:0] in_data, in_data2;
    logic        locked, err_pulse, locked2, err_pulse2;
    logic [15:0] err_count, err_count2;
    logic [1:0]  state, state2;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    int m_state, m_pred, m_good, m_miss, m_cnt, m_pulse;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clr_cnt(clr_cnt), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .state(state)
    );

    lfsr_checker #(.LOCK_COUNT(1), .MISS_LIMIT(15)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_data(in_data2),
        .clr_cnt(clr_cnt2), .locked(locked2), .err_pulse(err_pulse2),
        .err_count(err_count2), .state(state2)
    );

    function automatic int nx(input int w);
        return ((w << 1) & 'hFFF) | ($countones(w & 'h829) & 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        assert_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pred = 0; m_good = 0; m_miss = 0; m_cnt = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit clr);
        m_pulse = 0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 0) begin
                    m_pred = nx(d); m_good = 0; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (d == m_pred) begin
                    m_pred = nx(m_pred);
                    m_good++;
                    if (m_good == 4) begin
                        m_state = 2; m_miss = 0;
                    end
                end else begin
                    m_pred = nx(d); m_good = 0;
                    if (d == 0) m_state = 0;
                end
            end else begin
                if (d == m_pred) begin
                    m_miss = 0;
                end else begin
                    m_pulse = 1;
                    if (m_cnt < 'hFFFF) m_cnt++;
                    m_miss++;
                    if (m_miss == 3) begin
                        m_state = 0; m_miss = 0;
                    end
                end
                m_pred = nx(m_pred);
            end
        end
        if (clr) m_cnt = 0;
    endtask

    task automatic compare();
        chk("state", int'(state), m_state);
        chk("locked", int'(locked), (m_state == 2) ? 1 : 0);
        chk("err_pulse", int'(err_pulse), m_pulse);
        chk("err_count", int'(err_count), m_cnt);
    endtask

    task automatic step(input bit v, input int d, input bit clr);
        in_valid = v; in_data = d[11:0]; clr_cnt = clr;
        model_step(v, d & 'hFFF, clr);
        @(posedge clk);
        #1;
        compare();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_locked", int'(locked), 0);
        chk("arst_err_count", int'(err_count), 0);
        chk("arst_state", int'(state), 0);
        chk("arst_err_pulse", int'(err_pulse), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic step2(input int d, input bit clr);
        in_valid2 = 1'b1; in_data2 = d[11:0]; clr_cnt2 = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic main_test();
        int s, w, r, d;
        bit v;
        #3;
        chk("reset_state", int'(state), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_err_count", int'(err_count), 0);
        chk("reset_err_pulse", int'(err_pulse), 0);
        #19 rst_n = 1'b1;
        model_reset();

        chk("nx_b48", nx('hB48), 'h690);
        chk("nx_690", nx('h690), 'hD20);
        chk("nx_d20", nx('hD20), 'hA40);

        s = 'hB48;
        step(1, s, 0); s = nx(s);
        chk("verify_after_word1", int'(state), 1);
        for (int k = 1; k <= 4; k++) begin
            step(1, s, 0); s = nx(s);
            if (k == 3) chk("not_locked_after_3", int'(locked), 0);
        end
        chk("locked_after_4_matches", int'(locked), 1);
        chk("state_locked", int'(state), 2);

        step(0, 'h5A5, 0);
        chk("idle_holds_lock", int'(state), 2);

        step(1, 0, 0); s = nx(s);
        chk("zero_word_pulse", int'(err_pulse), 1);
        chk("zero_word_count", int'(err_count), 1);
        chk("zero_word_locked", int'(locked), 1);
        step(1, s, 0); s = nx(s);
        chk("flywheel_next_ok_pulse", int'(err_pulse), 0);
        chk("flywheel_next_ok_locked", int'(locked), 1);

        async_reset();
        step(1, 0, 0);
        chk("search_ignores_zero", int'(state), 0);

        s = 'hB48;
        for (int k = 0; k < 5; k++) begin
            step(1, s, 0); s = nx(s);
        end
        for (int k = 1; k <= 3; k++) begin
            step(1, s ^ 'h001, 0); s = nx(s);
            if (k == 2) chk("still_locked_after_2_miss", int'(locked), 1);
        end
        chk("loss_err_count", int'(err_count), 3);
        chk("loss_state", int'(state), 0);
        chk("loss_locked", int'(locked), 0);
        chk("loss_final_pulse", int'(err_pulse), 1);

        s = 'hB48;
        for (int k = 0; k < 3; k++) begin
            step(1, s, 0); s = nx(s);
        end
        step(1, 'h123, 0);
        chk("reseed_stays_verify", int'(state), 1);
        s = nx('h123);
        for (int k = 1; k <= 4; k++) begin
            step(1, s, 0); s = nx(s);
            if (k == 3) chk("reseed_not_locked_3", int'(locked), 0);
        end
        chk("reseed_locked_4", int'(locked), 1);

        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 500) async_reset();
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 80)      d = s;
            else if (r < 90) d = $urandom & 'hFFF;
            else if (r < 93) d = 0;
            else if (r < 99) d = s ^ (1 << $urandom_range(0, 11));
            else begin
                w = ($urandom_range(1, 4095));
                s = w; d = w;
            end
            step(v, d, ($urandom_range(0, 63) == 0));
            if (v) s = nx(s);
        end
    endtask

    task automatic sat_test();
        int s, mism;
        in_valid2 = 1'b0; in_data2 = 12'd0; clr_cnt2 = 1'b0;
        #22 rst2_n = 1'b1;
        step2('hB48, 0);
        step2('h690, 0);
        chk("sat_locked", int'(locked2), 1);
        s = 'hD20;
        mism = 0;
        for (int k = 0; mism < 65535; k++) begin
            if (k % 15 == 14) begin
                step2(s, 0);
                chk("sat_no_pulse", int'(err_pulse2), 0);
            end else begin
                step2(s ^ 'h800, 0);
                mism++;
                chk("sat_pulse", int'(err_pulse2), 1);
            end
            s = nx(s);
        end
        chk("sat_count_max", int'(err_count2), 'hFFFF);
        chk("sat_still_locked", int'(locked2), 1);
        step2(s, 0); s = nx(s);
        step2(s ^ 'h001, 0); s = nx(s);
        chk("sat_holds_max", int'(err_count2), 'hFFFF);
        chk("sat_hold_pulse", int'(err_pulse2), 1);
        step2(s ^ 'h001, 1); s = nx(s);
        chk("sat_clear_wins", int'(err_count2), 0);
        chk("sat_clear_pulse", int'(err_pulse2), 1);
        in_valid2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        in_valid = 1'b0; in_data = 12'd0; clr_cnt = 1'b0;
        in_valid2 = 1'b0; in_data2 = 12'd0; clr_cnt2 = 1'b0;
        model_reset();
        fork
            main_test();
            sat_test();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
